// File: rtl/shift_rotate_pipe.sv
// Pipelined log-depth barrel shifter (ROL/SLL/ROR/SRL/SRA) with elastic valid/ready
// handshake on both sides, flush, and a passthrough destination tag.
module shift_rotate_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 3,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] MODE_ROL = 3'b000;
  localparam logic [2:0] MODE_SLL = 3'b001;
  localparam logic [2:0] MODE_ROR = 3'b010;
  localparam logic [2:0] MODE_SRL = 3'b011;
  localparam logic [2:0] MODE_SRA = 3'b100;

  // One barrel level: move by 2^k; SRA fills from the original operand MSB.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input int k,
                                                   input logic [2:0] mode,
                                                   input logic msb);
    int n;
    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] sra;
    n   = 1 << k;
    ext = $signed({msb, d});
    sra = ext >>> n;
    case (mode)
      MODE_ROL: shift_level = (d << n) | (d >> (WIDTH - n));
      MODE_SLL: shift_level = d << n;
      MODE_ROR: shift_level = (d >> n) | (d << (WIDTH - n));
      MODE_SRL: shift_level = d >> n;
      MODE_SRA: shift_level = sra[WIDTH-1:0];
      default:  shift_level = d;
    endcase
  endfunction

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] rdy_p;
  logic [STAGES-1:0] nxt_vld;
  logic [WIDTH-1:0]  data_p   [STAGES];
  logic [AW-1:0]     amt_p    [STAGES];
  logic [2:0]        mode_p   [STAGES];
  logic              msb_p    [STAGES];
  logic [TAG_W-1:0]  tag_p    [STAGES];
  logic [WIDTH-1:0]  nxt_data [STAGES];
  logic [AW-1:0]     nxt_amt  [STAGES];
  logic [2:0]        nxt_mode [STAGES];
  logic              nxt_msb  [STAGES];
  logic [TAG_W-1:0]  nxt_tag  [STAGES];

  // A stage may load if any slot from it to the output is free, or the output drains.
  always_comb begin : ready_chain
    logic free;
    free  = out_ready;
    rdy_p = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      free     = free | !vld_p[s];
      rdy_p[s] = free;
    end
  end

  assign in_ready = rdy_p[0] & !flush;

  always_comb begin : stage_logic
    int               ps;
    logic [WIDTH-1:0] cur_data;
    logic [AW-1:0]    cur_amt;
    logic [2:0]       cur_mode;
    logic             cur_msb;
    logic [TAG_W-1:0] cur_tag;
    nxt_vld = '0;
    for (int s = 0; s < STAGES; s++) begin
      ps = (s == 0) ? 0 : s - 1;
      if (s == 0) begin
        nxt_vld[s] = in_valid & in_ready;
        cur_data   = in_data;
        cur_amt    = in_amt;
        cur_mode   = in_mode;
        cur_msb    = in_data[WIDTH-1];
        cur_tag    = in_tag;
      end else begin
        nxt_vld[s] = vld_p[ps];
        cur_data   = data_p[ps];
        cur_amt    = amt_p[ps];
        cur_mode   = mode_p[ps];
        cur_msb    = msb_p[ps];
        cur_tag    = tag_p[ps];
      end
      for (int k = 0; k < AW; k++) begin
        if (((k * STAGES) / AW == s) && cur_amt[k])
          cur_data = shift_level(cur_data, k, cur_mode, cur_msb);
      end
      nxt_data[s] = cur_data;
      nxt_amt[s]  = cur_amt;
      nxt_mode[s] = cur_mode;
      nxt_msb[s]  = cur_msb;
      nxt_tag[s]  = cur_tag;
    end
  end

  // Stage registers; flush wins over advance and kills every slot on the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_p[s] <= '0;
        amt_p[s]  <= '0;
        mode_p[s] <= '0;
        msb_p[s]  <= 1'b0;
        tag_p[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush)
          vld_p[s] <= 1'b0;
        else if (rdy_p[s])
          vld_p[s] <= nxt_vld[s];
        if (rdy_p[s] && nxt_vld[s] && !flush) begin
          data_p[s] <= nxt_data[s];
          amt_p[s]  <= nxt_amt[s];
          mode_p[s] <= nxt_mode[s];
          msb_p[s]  <= nxt_msb[s];
          tag_p[s]  <= nxt_tag[s];
        end
      end
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign out_data  = data_p[STAGES-1];
  assign out_tag   = tag_p[STAGES-1];
  assign out_zero  = (data_p[STAGES-1] == '0);

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Randomised bench for shift_rotate_pipe: three configurations share one stimulus
// stream, each checked against a bit-level behavioural model and scoreboard.
module tb_shift_rotate_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [63:0] din;
  logic [5:0]  amt6;
  logic [2:0]  mode, tag;

  logic        rdy_a, ov_a, oz_a;
  logic [15:0] od_a;
  logic [2:0]  ot_a;
  logic        rdy_b, ov_b, oz_b;
  logic [31:0] od_b;
  logic [2:0]  ot_b;
  logic        rdy_c, ov_c, oz_c;
  logic [7:0]  od_c;
  logic [2:0]  ot_c;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int acc_a = 0;
  bit lat_chk = 0;

  typedef struct {
    logic [63:0] d;
    logic [2:0]  tag;
    int          cyc;
  } exp_t;
  exp_t q[3][$];

  always #5 clk = ~clk;

  shift_rotate_pipe #(.WIDTH(16), .STAGES(2), .TAG_W(3)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(din[15:0]), .in_amt(amt6[3:0]), .in_mode(mode), .in_tag(tag),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_zero(oz_a), .out_tag(ot_a));

  shift_rotate_pipe #(.WIDTH(32), .STAGES(5), .TAG_W(3)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(din[31:0]), .in_amt(amt6[4:0]), .in_mode(mode), .in_tag(tag),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_zero(oz_b), .out_tag(ot_b));

  shift_rotate_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(3)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_data(din[7:0]), .in_amt(amt6[2:0]), .in_mode(mode), .in_tag(tag),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_zero(oz_c), .out_tag(ot_c));

  // Result bit i is taken from the operand bit it must come from.
  function automatic logic [63:0] model(input logic [63:0] d, input int a,
                                        input logic [2:0] m, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        3'd0: r[i] = d[(i - a + w) % w];
        3'd1: if (i >= a) r[i] = d[i - a];
        3'd2: r[i] = d[(i + a) % w];
        3'd3: if (i + a < w) r[i] = d[i + a];
        3'd4: r[i] = (i + a < w) ? d[(i + a) % w] : d[w - 1];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic mon(input int i, input int w, input int st, input logic ir,
                     input logic ov, input logic [63:0] od, input logic oz,
                     input logic [2:0] ot, input int a);
    exp_t e;
    if (ov) begin
      if (q[i].size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_out[%0d]: got data %h, expected no result", i, od);
      end else begin
        e = q[i][0];
        check($sformatf("data[%0d]", i), od, e.d);
        check($sformatf("tag[%0d]", i), 64'(ot), 64'(e.tag));
        check($sformatf("zero[%0d]", i), 64'(oz), 64'(e.d == 64'd0));
        if (out_ready) begin
          if (lat_chk) check($sformatf("latency[%0d]", i), 64'(cyc - e.cyc), 64'(st));
          void'(q[i].pop_front());
        end
      end
    end
    if (flush) q[i].delete();
    else if (in_valid && ir) begin
      e.d   = model(din, a, mode, w);
      e.tag = tag;
      e.cyc = cyc;
      q[i].push_back(e);
    end
  endtask

  // Single compare process, sampling just before each rising edge.
  always @(negedge clk) begin
    #4;
    cyc++;
    if (rst) begin
      if (in_valid && rdy_a) acc_a++;
      mon(0, 16, 2, rdy_a, ov_a, 64'(od_a), oz_a, ot_a, int'(amt6[3:0]));
      mon(1, 32, 5, rdy_b, ov_b, 64'(od_b), oz_b, ot_b, int'(amt6[4:0]));
      mon(2, 8, 1, rdy_c, ov_c, 64'(od_c), oz_c, ot_c, int'(amt6[2:0]));
    end
  end

  task automatic drive(input logic [63:0] d, input logic [5:0] a, input logic [2:0] m,
                       input logic [2:0] t);
    in_valid = 1'b1;
    din = d;
    amt6 = a;
    mode = m;
    tag = t;
  endtask

  task automatic send(input logic [63:0] d, input logic [5:0] a, input logic [2:0] m,
                      input logic [2:0] t);
    bit got;
    got = 0;
    drive(d, a, m, t);
    for (int i = 0; i < 100 && !got; i++) begin
      #4;
      got = rdy_a;
      @(negedge clk);
    end
    if (!got) begin
      nchk++;
      nfail++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
      @(negedge clk);
    end
    check("drain_a", 64'(q[0].size()), 64'd0);
    check("drain_b", 64'(q[1].size()), 64'd0);
    check("drain_c", 64'(q[2].size()), 64'd0);
  endtask

  task automatic wait_out_a();
    bit seen;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #4;
      seen = ov_a;
      if (!seen) @(negedge clk);
    end
    check("wait_out_a", 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    bit got;
    logic [2:0] dmodes [6];
    dmodes = '{3'd3, 3'd4, 3'd1, 3'd0, 3'd2, 3'd5};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    din = '0; amt6 = '0; mode = '0; tag = '0;
    #1 rst = 1'b0;
    #2;
    check("reset_out_valid", 64'(ov_a), 64'd0);
    check("reset_out_data", 64'(od_a), 64'd0);
    check("reset_out_tag", 64'(ot_a), 64'd0);
    check("reset_out_zero", 64'(oz_a), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #4 check("in_ready_after_reset", 64'(rdy_a), 64'd1);
    @(negedge clk);

    // Hand-computed values pin the model.
    check("model_srl", model(64'h8FFF, 4, 3'd3, 16), 64'h08FF);
    check("model_sra", model(64'h8FFF, 4, 3'd4, 16), 64'hF8FF);
    check("model_sll", model(64'h8FFF, 4, 3'd1, 16), 64'hFFF0);
    check("model_rol", model(64'h8FFF, 4, 3'd0, 16), 64'hFFF8);
    check("model_ror", model(64'h8FFF, 4, 3'd2, 16), 64'hF8FF);
    check("model_pass", model(64'h8FFF, 4, 3'd5, 16), 64'h8FFF);
    check("model_sll_edge", model(64'h8000, 1, 3'd1, 16), 64'h0000);
    check("model_sra_edge", model(64'h8000, 15, 3'd4, 16), 64'hFFFF);

    lat_chk = 1;
    for (int i = 0; i < 6; i++) send(64'h8FFF, 6'd4, dmodes[i], 3'(i + 1));
    drain();

    send(64'h8000, 6'd1, 3'd1, 3'd6);
    in_valid = 1'b0;
    wait_out_a();
    check("sll_8000_data", 64'(od_a), 64'h0000);
    check("sll_8000_zero", 64'(oz_a), 64'd1);
    @(negedge clk);
    drain();
    send(64'h8000, 6'd15, 3'd4, 3'd7);
    in_valid = 1'b0;
    wait_out_a();
    check("sra_8000_data", 64'(od_a), 64'hFFFF);
    check("sra_8000_zero", 64'(oz_a), 64'd0);
    @(negedge clk);
    drain();

    for (int m = 0; m < 8; m++)
      for (int a = 0; a < 16; a++)
        send({$urandom, $urandom}, {2'($urandom), 4'(a)}, 3'(m), 3'($urandom));
    drain();
    lat_chk = 0;

    // Backpressure: only the two slots fill.
    out_ready = 1'b0;
    base = acc_a;
    drive({$urandom, $urandom}, 6'($urandom), 3'($urandom), 3'($urandom));
    for (int i = 0; i < 5; i++) begin
      #4;
      got = rdy_a;
      @(negedge clk);
      if (got) drive({$urandom, $urandom}, 6'($urandom), 3'($urandom), 3'($urandom));
    end
    check("bp_accepted", 64'(acc_a - base), 64'd2);
    #4 check("bp_in_ready", 64'(rdy_a), 64'd0);
    @(negedge clk);
    drain();

    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      din = {$urandom, $urandom};
      amt6 = 6'($urandom);
      mode = 3'($urandom);
      tag = 3'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    drain();

    // Flush with an offered operation.
    send({$urandom, $urandom}, 6'($urandom), 3'($urandom), 3'd1);
    send({$urandom, $urandom}, 6'($urandom), 3'($urandom), 3'd2);
    drive({$urandom, $urandom}, 6'($urandom), 3'($urandom), 3'd3);
    flush = 1'b1;
    #4 check("flush_in_ready", 64'(rdy_a), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4 check("flush_out_valid", 64'(ov_a), 64'd0);
      @(negedge clk);
    end
    lat_chk = 1;
    send({$urandom, $urandom}, 6'($urandom), 3'($urandom), 3'd4);
    drain();
    lat_chk = 0;

    // Asynchronous reset mid-cycle with a full pipeline.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive({$urandom, $urandom}, 6'($urandom), 3'($urandom), 3'($urandom));
      @(negedge clk);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) q[i].delete();
    #1;
    check("async_rst_out_valid", 64'(ov_a), 64'd0);
    check("async_rst_out_data", 64'(od_a), 64'd0);
    check("async_rst_out_zero", 64'(oz_a), 64'd1);
    check("async_rst_out_valid_b", 64'(ov_b), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    #4 check("rst_release_in_ready", 64'(rdy_a), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #4 check("no_stale_out", 64'(ov_a | ov_b | ov_c), 64'd0);
    end
    @(negedge clk);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/shift_rotate_pipe.md
# shift_rotate_pipe

Parametrised, pipelined shift/rotate unit for the execute stage. It replaces the single-cycle 16-bit combinational shifter with a log-depth barrel shifter split across a configurable number of register stages. It supports logical, arithmetic and rotate modes, uses a valid/ready elastic handshake on both sides, and can be flushed. A tag (destination register index) travels with each operation so the writeback result can be steered.

## Interface
- WIDTH, 16, data width; power of two, 8..64
- STAGES, 2, register stages; 1 ≤ STAGES ≤ AW, where AW = $clog2(WIDTH)
- TAG_W, 3, width of the passthrough tag
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all in-flight operations
- in_valid  input  1  operation offered
- in_ready  output  1  unit accepts the operation this cycle
- in_data  input  WIDTH  operand
- in_amt  input  AW  shift/rotate amount, 0..WIDTH-1
- in_mode  input  3  000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 SRA; 101–111 pass-through
- in_tag  input  TAG_W  opaque tag
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0
- out_tag  output  TAG_W  tag of the result

## Operation
- Shift levels k = 0..AW-1 each conditionally shift/rotate by 2^k when in_amt[k] = 1.
- Level k is evaluated in stage floor(k·STAGES/AW). Each stage ends in a register holding valid, data, remaining amount bits, mode and tag.
- Right modes shift toward the LSB:
  - SRL fills with 0.
  - SRA fills with the original operand MSB, carried in the stage register.
  - ROR wraps the low bits to the top.
- Left modes:
  - SLL fills with 0.
  - ROL wraps the high bits to the bottom.
- Pass-through modes output in_data unchanged.
- Amount 0 returns in_data for every mode.
- Results leave strictly in acceptance order; there is no reordering or merging.
- Per-stage advance: stage s loads when its successor slot is free or draining: ready_s = !valid_s | ready_{s+1}. The last stage uses ready = !out_valid | out_ready.
- in_ready = ready_0 & !flush.
- A transfer occurs only when valid & ready are both 1 on a rising edge.
- out_zero is computed from the registered out_data and is never stale.

## Timing
- Latency: an operation accepted on edge N presents out_valid at edge N+STAGES, provided there is no backpressure.
- Throughput: one operation per cycle while out_ready = 1.
- Backpressure: when out_ready = 0, the pipeline fills. in_ready falls once all STAGES slots are valid. Held outputs stay stable until accepted.
- Reset (rst = 0, asynchronous):
  - All valid bits clear; out_valid = 0.
  - out_data = 0, out_tag = 0; out_zero = 1.
  - in_ready = 1 from the first edge after rst deasserts.
  - Reset mid-operation discards all in-flight work, with no partial output.
- Flush:
  - Flush has priority over accept and advance.
  - in_ready = 0 during the flush cycle, so an offered operation is not taken.
  - On the next edge every valid bit clears.
  - A result showing out_valid in the flush cycle with out_ready = 1 counts as delivered; without out_ready it is dropped.
- Simultaneous accept and drain with a full pipeline: permitted. in_ready = 1 when out_ready = 1, and all stages shift together.
- Width rule: in_amt is exactly AW bits, so no amount ≥ WIDTH is representable.

## Test plan
- WIDTH=16, STAGES=2, in_data=16'h8FFF, in_amt=4 with each mode → SRL 16'h08FF, SRA 16'hF8FF, SLL 16'hFFF0, ROL 16'hFFF8, ROR 16'hF8FF, mode 101 → 16'h8FFF. Each result appears 2 cycles after accept with the matching tag.
- All modes × in_amt 0..15 back-to-back, with random data and out_ready=1 → one result per cycle, in order, every result equal to a behavioural model, latency constant at 2.
- Continuous input with out_ready held 0 for 5 cycles → exactly 2 operations are accepted, after which in_ready=0. After release, results drain in order with none lost or duplicated.
- SLL 16'h8000 by 1 → out_data=16'h0000, out_zero=1. SRA 16'h8000 by 15 → 16'hFFFF, out_zero=0.
- Two operations in flight, then a flush pulse with in_valid=1 → the offered operation is not accepted and out_valid stays 0 afterwards. The next operation issued behaves normally.
- rst asserted asynchronously mid-cycle with the pipeline full → out_valid falls immediately, out_data=0, out_zero=1. After release, in_ready=1 and no stale results appear.
- Repeat the sweep with WIDTH=32/STAGES=5 and WIDTH=8/STAGES=1 → model match, latency equal to STAGES.
